rll_key_gate_bank: RTL and testbench



---
 rtl/rll_key_gate_bank.sv | 147 ++++++++++++++
 tb/tb_rll_key_gate_bank.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rll_key_gate_bank.sv
// Serially loaded key register with shadow/commit, XOR/XNOR key-gate bank
// and a PIPE_STAGES-deep valid/data pipeline on the gated word.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   key_start       : begin or restart a serial key load
//   key_valid       : key_bit is valid this cycle
//   key_bit         : serial key bit, LSB first
//   key_zeroize     : clear shadow and active keys immediately
//   key_busy        : high while a load is in progress or committing
//   key_loaded      : active key came from a completed load
//   in_valid        : input data valid
//   in_data         : plaintext data word
//   out_valid       : output data valid
//   out_data        : key-gated data word
module rll_key_gate_bank #(
    parameter int KEY_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] GATE_POL = DATA_WIDTH'(32'h0000_FFFF),
    parameter int PIPE_STAGES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_start,
    input  logic                  key_valid,
    input  logic                  key_bit,
    input  logic                  key_zeroize,
    output logic                  key_busy,
    output logic                  key_loaded,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int CW = $clog2(KEY_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_ARMED
    } state_t;

    state_t                r_state;
    state_t                w_state_n;
    logic [KEY_WIDTH-1:0]  r_shadow;
    logic [KEY_WIDTH-1:0]  w_shadow_n;
    logic [KEY_WIDTH-1:0]  r_active;
    logic [KEY_WIDTH-1:0]  w_active_n;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_n;
    logic                  r_loaded;
    logic                  w_loaded_n;
    logic                  r_busy;
    logic                  w_busy_n;
    logic [DATA_WIDTH-1:0] w_gate;

    logic [PIPE_STAGES-1:0] r_pv;
    logic [DATA_WIDTH-1:0]  r_pd [PIPE_STAGES];

    // Key FSM: zeroize beats start beats key_valid in every state.
    always_comb begin
        w_state_n  = r_state;
        w_shadow_n = r_shadow;
        w_active_n = r_active;
        w_cnt_n    = r_cnt;
        w_loaded_n = r_loaded;
        if (key_zeroize) begin
            w_state_n  = S_IDLE;
            w_shadow_n = '0;
            w_active_n = '0;
            w_cnt_n    = '0;
            w_loaded_n = 1'b0;
        end else if (key_start) begin
            w_state_n = S_LOAD;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (key_valid) begin
                        // Decoded write avoids an index wider than the key.
                        for (int i = 0; i < KEY_WIDTH; i++) begin
                            if (r_cnt == CW'(i)) w_shadow_n[i] = key_bit;
                        end
                        w_cnt_n = r_cnt + CW'(1);
                        if (r_cnt == CW'(KEY_WIDTH - 1)) w_state_n = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    w_active_n = r_shadow;
                    w_loaded_n = 1'b1;
                    w_state_n  = S_ARMED;
                end
                default: ;
            endcase
        end
        w_busy_n = (w_state_n == S_LOAD) || (w_state_n == S_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_loaded <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_shadow <= w_shadow_n;
            r_active <= w_active_n;
            r_cnt    <= w_cnt_n;
            r_loaded <= w_loaded_n;
            r_busy   <= w_busy_n;
        end
    end

    // Gate i reuses key bit (i mod KEY_WIDTH); polarity 1 turns XOR into XNOR.
    always_comb begin
        w_gate = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_gate[i] = in_data[i] ^ r_active[i % KEY_WIDTH] ^ GATE_POL[i];
        end
    end

    // Valid always shifts; data registers only load behind a valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) r_pd[k] <= '0;
        end else begin
            r_pv[0] <= in_valid;
            if (in_valid) r_pd[0] <= w_gate;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                r_pv[k] <= r_pv[k-1];
                if (r_pv[k-1]) r_pd[k] <= r_pd[k-1];
            end
        end
    end

    assign key_busy   = r_busy;
    assign key_loaded = r_loaded;
    assign out_valid  = r_pv[PIPE_STAGES-1];
    assign out_data   = r_pd[PIPE_STAGES-1];

endmodule

// File: tb/tb_rll_key_gate_bank.sv
// Self-checking bench for rll_key_gate_bank: directed scenarios plus
// randomized traffic against a behavioural key/datapath model.
module tb_rll_key_gate_bank;

    localparam int KW = 32;
    localparam logic [31:0] POL = 32'h0000_FFFF;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_COMMIT = 2, PH_ARMED = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, key_start = 1'b0, key_valid = 1'b0;
    logic        key_bit = 1'b0, key_zeroize = 1'b0, in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        key_busy, key_loaded, out_valid;
    logic [31:0] out_data;

    logic        p_rst = 1'b1, p_start = 1'b0, p_valid = 1'b0;
    logic        p_bit = 1'b0, p_zero = 1'b0, p_in_valid = 1'b0;
    logic [39:0] p_in_data = '0;
    logic        p_busy, p_loaded, p_out_valid;
    logic [39:0] p_out_data;

    rll_key_gate_bank dut (
        .clk(clk), .rst(rst), .key_start(key_start), .key_valid(key_valid),
        .key_bit(key_bit), .key_zeroize(key_zeroize), .key_busy(key_busy),
        .key_loaded(key_loaded), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data)
    );

    rll_key_gate_bank #(
        .KEY_WIDTH(32), .DATA_WIDTH(40), .GATE_POL(40'h0), .PIPE_STAGES(3)
    ) dut3 (
        .clk(clk), .rst(p_rst), .key_start(p_start), .key_valid(p_valid),
        .key_bit(p_bit), .key_zeroize(p_zero), .key_busy(p_busy),
        .key_loaded(p_loaded), .in_valid(p_in_valid), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_data(p_out_data)
    );

    int n_pass = 0;
    int n_chk = 0;

    // Behavioural model of the default instance.
    int          m_phase = PH_IDLE;
    int          m_cnt = 0;
    logic [31:0] m_shadow = '0, m_active = '0, m_od = '0;
    logic        m_loaded = 1'b0, m_busy = 1'b0, m_ov = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst) begin
            m_phase = PH_IDLE; m_cnt = 0; m_shadow = '0; m_active = '0;
            m_od = '0; m_ov = 1'b0; m_loaded = 1'b0;
        end else begin
            m_ov = in_valid;
            if (in_valid) m_od = in_data ^ m_active ^ POL;
            if (key_zeroize) begin
                m_phase = PH_IDLE; m_cnt = 0; m_shadow = '0;
                m_active = '0; m_loaded = 1'b0;
            end else if (key_start) begin
                m_phase = PH_LOAD; m_cnt = 0;
            end else if (m_phase == PH_LOAD && key_valid) begin
                m_shadow[m_cnt] = key_bit;
                m_cnt++;
                if (m_cnt == KW) m_phase = PH_COMMIT;
            end else if (m_phase == PH_COMMIT) begin
                m_active = m_shadow; m_loaded = 1'b1; m_phase = PH_ARMED;
            end
        end
        m_busy = (m_phase == PH_LOAD) || (m_phase == PH_COMMIT);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        n_chk++;
        if ({out_valid, key_busy, key_loaded, out_data} !== 35'h0)
            $display("FAIL reset_state got=%h exp=0",
                     {out_valid, key_busy, key_loaded, out_data});
        else n_pass++;
        rst = 1'b0;
        in_valid = 1'b1; in_data = 32'hA5A5_A5A5;
        cyc();
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_5A5A)
            $display("FAIL reset_gate v=%b d=%h exp v=1 d=a5a55a5a",
                     out_valid, out_data);
        else n_pass++;
        n_chk++;
        if (key_loaded !== 1'b0)
            $display("FAIL reset_loaded got=%b exp=0", key_loaded);
        else n_pass++;
        cyc();
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 32'hA5A5_5A5A)
            $display("FAIL reset_hold v=%b d=%h exp v=0 d=a5a55a5a",
                     out_valid, out_data);
        else n_pass++;
    endtask

    task automatic load_key(input logic [31:0] k, input string nm);
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            key_valid = 1'b1; key_bit = k[i];
            cyc();
            n_chk++;
            if ({out_valid, key_busy, key_loaded, out_data} !==
                {m_ov, m_busy, m_loaded, m_od})
                $display("FAIL %s_bit%0d got=%h exp=%h", nm, i,
                         {out_valid, key_busy, key_loaded, out_data},
                         {m_ov, m_busy, m_loaded, m_od});
            else n_pass++;
        end
        key_valid = 1'b0;
    endtask

    task automatic test_key_load();
        in_valid = 1'b1; in_data = '0;
        load_key(32'h1234_5678, "load");
        n_chk++;
        if (key_busy !== 1'b1 || key_loaded !== 1'b0)
            $display("FAIL load_commit busy=%b loaded=%b exp 1 0",
                     key_busy, key_loaded);
        else n_pass++;
        cyc();
        n_chk++;
        if (key_busy !== 1'b0 || key_loaded !== 1'b1)
            $display("FAIL load_armed busy=%b loaded=%b exp 0 1",
                     key_busy, key_loaded);
        else n_pass++;
        n_chk++;
        if (out_data !== 32'h0000_FFFF)
            $display("FAIL load_commit_oldkey got=%h exp=0000ffff", out_data);
        else n_pass++;
        cyc();
        n_chk++;
        if (out_data !== 32'h1234_A987)
            $display("FAIL load_newkey got=%h exp=1234a987", out_data);
        else n_pass++;
    endtask

    task automatic test_abort_reload();
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_valid = 1'b1; key_bit = 1'b1;
            cyc();
            n_chk++;
            if (out_data !== 32'h1234_A987)
                $display("FAIL abort_partial%0d got=%h exp=1234a987",
                         i, out_data);
            else n_pass++;
        end
        load_key(32'hFFFF_FFFF, "reload");
        cyc();
        n_chk++;
        if (out_data !== 32'h1234_A987)
            $display("FAIL reload_commit got=%h exp=1234a987", out_data);
        else n_pass++;
        cyc();
        n_chk++;
        if (out_data !== 32'hFFFF_0000 || key_loaded !== 1'b1)
            $display("FAIL reload_new d=%h l=%b exp ffff0000 1",
                     out_data, key_loaded);
        else n_pass++;
    endtask

    task automatic test_zeroize();
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1; key_bit = 1'b1;
            cyc();
        end
        key_zeroize = 1'b1; key_start = 1'b1; key_valid = 1'b1;
        cyc();
        key_zeroize = 1'b0; key_start = 1'b0; key_valid = 1'b0;
        n_chk++;
        if (key_busy !== 1'b0 || key_loaded !== 1'b0)
            $display("FAIL zeroize_flags busy=%b loaded=%b exp 0 0",
                     key_busy, key_loaded);
        else n_pass++;
        cyc();
        n_chk++;
        if (out_data !== 32'h0000_FFFF)
            $display("FAIL zeroize_data got=%h exp=0000ffff", out_data);
        else n_pass++;
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        n_chk++;
        if (key_busy !== 1'b0 || out_data !== 32'h0000_FFFF)
            $display("FAIL zeroize_idle_ignore busy=%b d=%h exp 0 0000ffff",
                     key_busy, out_data);
        else n_pass++;
    endtask

    task automatic test_rst_midload();
        key_start = 1'b1;
        cyc();
        key_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            key_valid = 1'b1; key_bit = 1'b1;
            cyc();
        end
        key_valid = 1'b0;
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        cyc();
        rst = 1'b0; in_data = '0;
        n_chk++;
        if ({out_valid, key_busy, key_loaded, out_data} !== 35'h0)
            $display("FAIL rst_midload got=%h exp=0",
                     {out_valid, key_busy, key_loaded, out_data});
        else n_pass++;
        load_key(32'h1234_5678, "postrst");
        cyc(); cyc();
        n_chk++;
        if (out_data !== 32'h1234_A987 || key_loaded !== 1'b1)
            $display("FAIL postrst_key d=%h l=%b exp 1234a987 1",
                     out_data, key_loaded);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            key_zeroize = ($urandom_range(0, 199) == 0);
            key_start = ($urandom_range(0, 89) == 0);
            key_valid = ($urandom_range(0, 3) != 0);
            key_bit = 1'($urandom);
            in_valid = 1'($urandom);
            in_data = $urandom;
            cyc();
            n_chk++;
            if ({out_valid, key_busy, key_loaded, out_data} !==
                {m_ov, m_busy, m_loaded, m_od})
                $display("FAIL random_c%0d got=%h exp=%h", c,
                         {out_valid, key_busy, key_loaded, out_data},
                         {m_ov, m_busy, m_loaded, m_od});
            else n_pass++;
        end
        rst = 1'b0; key_zeroize = 1'b0; key_start = 1'b0;
        key_valid = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_pipe3();
        logic [31:0] k;
        k = 32'h0000_00FF;
        p_rst = 1'b1;
        cyc();
        p_rst = 1'b0; p_start = 1'b1;
        cyc();
        p_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            p_valid = 1'b1; p_bit = k[i];
            cyc();
        end
        p_valid = 1'b0;
        cyc(); cyc();
        n_chk++;
        if (p_loaded !== 1'b1 || p_out_valid !== 1'b0)
            $display("FAIL pipe3_armed l=%b v=%b exp 1 0",
                     p_loaded, p_out_valid);
        else n_pass++;
        p_in_valid = 1'b1; p_in_data = 40'h0;
        cyc();
        p_in_data = 40'hFF_FFFF_FFFF;
        cyc();
        p_in_valid = 1'b0; p_in_data = 40'h0;
        n_chk++;
        if (p_out_valid !== 1'b0)
            $display("FAIL pipe3_early v=%b exp 0", p_out_valid);
        else n_pass++;
        cyc();
        n_chk++;
        if (p_out_valid !== 1'b1 || p_out_data !== 40'hFF_0000_00FF)
            $display("FAIL pipe3_w0 v=%b d=%h exp 1 ff000000ff",
                     p_out_valid, p_out_data);
        else n_pass++;
        cyc();
        n_chk++;
        if (p_out_valid !== 1'b1 || p_out_data !== 40'h00_FFFF_FF00)
            $display("FAIL pipe3_w1 v=%b d=%h exp 1 00ffffff00",
                     p_out_valid, p_out_data);
        else n_pass++;
        cyc();
        n_chk++;
        if (p_out_valid !== 1'b0 || p_out_data !== 40'h00_FFFF_FF00)
            $display("FAIL pipe3_tail v=%b d=%h exp 0 00ffffff00",
                     p_out_valid, p_out_data);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_abort_reload();
        test_zeroize();
        test_rst_midload();
        test_random();
        test_pipe3();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
